// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and data memory: a circular FIFO of pending stores
// that drains in program order, with load lookup. Define STB_FORWARD_EN to forward store data to loads instead of stalling them.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_req,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  input  logic                     drain_hold,
  output logic                     mem_write,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occ;
  logic          enq;
  logic          deq;
  logic          match;
  logic [PW-1:0] idx;
`ifdef STB_FORWARD_EN
  logic [DW-1:0] match_data;
`endif

  // Status is derived only from the registered occupancy, so all three always agree.
  assign count    = occ;
  assign empty    = (occ == '0);
  assign full     = (occ == CW'(DEPTH));
  assign st_ready = !full;

  assign enq       = st_valid && !full;
  assign deq       = !empty && !drain_hold;
  assign mem_write = deq;
  assign mem_addr  = empty ? '0 : addr_mem[head];
  assign mem_wdata = empty ? '0 : data_mem[head];

  // NOTE: entry storage has no reset; the occupancy counter alone decides which
  // entries are valid, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= st_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      unique case ({enq, deq})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Walk entries oldest to youngest so the last match seen is the youngest store.
  // The entry draining this cycle is still counted; one being written is not yet.
  // NOTE: every always_comb output gets a default first, which rules out latches.
  always_comb begin
    match = 1'b0;
    idx   = head;
`ifdef STB_FORWARD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < occ) && (addr_mem[idx] == ld_addr)) begin
        match = 1'b1;
`ifdef STB_FORWARD_EN
        match_data = data_mem[idx];
`endif
      end
    end
  end

`ifdef STB_FORWARD_EN
  assign ld_hit   = ld_req && match;
  assign ld_data  = (ld_req && match) ? match_data : '0;
  assign ld_stall = 1'b0;
`else
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = ld_req && match;
`endif

endmodule
